// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Sequences the shared multi-cycle multiply/divide unit for the 5-stage
//   pipeline. A mul/div in D/X launches the unit with a one-cycle start pulse.
//   The sequencer then stalls F/D and D/X until the unit is ready or a timeout
//   expires. The captured result is then presented for one cycle so the
//   instruction can advance into X/M.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   opcode_DX, aluop_DX decode fields of the D/X instruction
//   kill                D/X flush (taken branch/jump)
//   data_resultRDY      unit result valid
//   data_exception      unit exception
//   data_result         unit result
//   ctrl_MULT/ctrl_DIV  start pulses to the unit (launch cycle only)
//   stall_md            hold PC, F/D, D/X; insert a nop into X/M
//   md_valid            one-cycle strobe: md_* belong to the D/X instruction
//   md_result           captured result
//   md_exception        captured exception
//   md_is_div           captured op type (rstatus 5 for div, 4 for mul)
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT   = 40,
  parameter int unsigned CNT_W     = 6,
  parameter logic [4:0]  MUL_ALUOP = 5'b00110,
  parameter logic [4:0]  DIV_ALUOP = 5'b00111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  opcode_DX,
  input  logic [4:0]  aluop_DX,
  input  logic        kill,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall_md,
  output logic        md_valid,
  output logic [31:0] md_result,
  output logic        md_exception,
  output logic        md_is_div
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      result_q;
  logic             exc_q;
  logic             is_div_q;

  logic is_mul, is_div, is_md, launch;

  assign is_mul = (opcode_DX == 5'b00000) && (aluop_DX == MUL_ALUOP);
  assign is_div = (opcode_DX == 5'b00000) && (aluop_DX == DIV_ALUOP);
  assign is_md  = is_mul || is_div;

  // Launch is decided combinationally so the start pulse and the stall
  // appear in the same cycle the instruction is seen in D/X. Reset masks
  // every strobe so outputs read 0 while reset is held.
  assign launch = !reset && (state_q == IDLE) && is_md && !kill;

  assign ctrl_MULT    = launch && is_mul;
  assign ctrl_DIV     = launch && is_div;
  assign stall_md     = launch || (!reset && (state_q == BUSY));
  assign md_valid     = !reset && (state_q == DONE);
  assign md_result    = result_q;
  assign md_exception = exc_q;
  assign md_is_div    = is_div_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // data_resultRDY is deliberately ignored here, even on launch.
          if (launch) begin
            is_div_q <= is_div;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          // Priority: kill, then ready, then timeout. The counter holds at
          // its last value when leaving BUSY so it never wraps.
          if (kill) begin
            state_q <= IDLE;
          end else if (data_resultRDY) begin
            result_q <= data_result;
            exc_q    <= data_exception;
            state_q  <= DONE;
          end else if (cnt_q == CntLast) begin
            result_q <= '0;
            exc_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;
  localparam logic [4:0] RTYPE = 5'b00000;
  localparam logic [4:0] NONR  = 5'b00101;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  opcode_DX;
  logic [4:0]  aluop_DX;
  logic        kill;
  logic        data_resultRDY;
  logic        data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall_md;
  logic        md_valid;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_is_div;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_sequencer #(
    .TIMEOUT  (40),
    .CNT_W    (6),
    .MUL_ALUOP(MUL),
    .DIV_ALUOP(DIV)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .opcode_DX     (opcode_DX),
    .aluop_DX      (aluop_DX),
    .kill          (kill),
    .data_resultRDY(data_resultRDY),
    .data_exception(data_exception),
    .data_result   (data_result),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .stall_md      (stall_md),
    .md_valid      (md_valid),
    .md_result     (md_result),
    .md_exception  (md_exception),
    .md_is_div     (md_is_div)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] alu, input logic k,
                       input logic rdy, input logic [31:0] res, input logic exc);
    opcode_DX      = op;
    aluop_DX       = alu;
    kill           = k;
    data_resultRDY = rdy;
    data_result    = res;
    data_exception = exc;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Runs one op from cycle k0 (0 = launch cycle). The unit's ready pulse is
  // driven at cycle rdy_at (-1: never); kill at kill_at (-1: never). Between
  // ready pulses the unit data lines carry junk that must not be captured.
  // A trailing cycle follows with either a nop or a new mul in D/X.
  task automatic do_op(input bit op_div, input int k0, input int rdy_at, input int kill_at,
                       input logic [31:0] res, input logic exc, input bit follow_md,
                       output int stalls, output int n_mul, output int n_div,
                       output int n_valid, output int valid_k,
                       output int trail_stall, output int trail_mul);
    bit done = 1'b0;
    bit present;
    int k = k0;
    stalls = 0; n_mul = 0; n_div = 0; n_valid = 0; valid_k = -1;
    while (!done && k < k0 + 60) begin
      present = !(kill_at >= 0 && k > kill_at);
      drive(present ? RTYPE : NONR, op_div ? DIV : MUL, k == kill_at,
            k == rdy_at, (k == rdy_at) ? res : 32'hDEAD_BEEF,
            (k == rdy_at) ? exc : 1'b1);
      #4;
      stalls += int'(stall_md);
      n_mul  += int'(ctrl_MULT);
      n_div  += int'(ctrl_DIV);
      if (md_valid) begin
        n_valid++;
        if (valid_k < 0) valid_k = k;
      end
      next_cycle();
      if (valid_k >= 0 || (kill_at >= 0 && k >= kill_at + 2)) done = 1'b1;
      k++;
    end
    if (!done) check("op_bound", 32'd0, 32'd1);
    drive(follow_md ? RTYPE : NONR, MUL, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    #4;
    trail_stall = int'(stall_md);
    trail_mul   = int'(ctrl_MULT);
    check("trail_valid", 32'(md_valid), 32'd0);
    next_cycle();
  endtask

  int st, nm, nd, nv, vk, ts, tm;

  initial begin
    reset = 1'b1;
    drive(NONR, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #4;
    check("rst_mult",  32'(ctrl_MULT), 32'd0);
    check("rst_div",   32'(ctrl_DIV), 32'd0);
    check("rst_stall", 32'(stall_md), 32'd0);
    check("rst_valid", 32'(md_valid), 32'd0);
    check("rst_res",   md_result, 32'd0);
    check("rst_exc",   32'(md_exception), 32'd0);
    check("rst_isdiv", 32'(md_is_div), 32'd0);
    next_cycle();

    // Kill in IDLE suppresses launch.
    drive(RTYPE, MUL, 1'b1, 1'b0, 32'd0, 1'b0);
    #4;
    check("kidle_mult",  32'(ctrl_MULT), 32'd0);
    check("kidle_stall", 32'(stall_md), 32'd0);
    next_cycle();
    drive(NONR, MUL, 1'b0, 1'b0, 32'd0, 1'b0);
    #4;
    check("kidle_after", 32'(stall_md), 32'd0);
    next_cycle();

    // mul, ready 32 cycles after the pulse.
    do_op(1'b0, 0, 32, -1, 32'h0000_0F00, 1'b0, 1'b0, st, nm, nd, nv, vk, ts, tm);
    check("mul_pulses", nm, 32'd1);
    check("mul_divp",   nd, 32'd0);
    check("mul_stall",  st, 32'd33);
    check("mul_nvalid", nv, 32'd1);
    check("mul_validk", vk, 32'd33);
    check("mul_trail",  ts, 32'd0);
    check("mul_res",    md_result, 32'h0000_0F00);
    check("mul_exc",    32'(md_exception), 32'd0);
    check("mul_isdiv",  32'(md_is_div), 32'd0);

    // div by zero, exception after 5 cycles.
    do_op(1'b1, 0, 5, -1, 32'hFFFF_FFFF, 1'b1, 1'b0, st, nm, nd, nv, vk, ts, tm);
    check("div_pulses", nd, 32'd1);
    check("div_mulp",   nm, 32'd0);
    check("div_stall",  st, 32'd6);
    check("div_validk", vk, 32'd6);
    check("div_res",    md_result, 32'hFFFF_FFFF);
    check("div_exc",    32'(md_exception), 32'd1);
    check("div_isdiv",  32'(md_is_div), 32'd1);

    // kill on 3rd BUSY cycle, ready on 4th: no capture.
    do_op(1'b0, 0, 4, 3, 32'h1234_5678, 1'b0, 1'b0, st, nm, nd, nv, vk, ts, tm);
    check("kill_stall",  st, 32'd4);
    check("kill_nvalid", nv, 32'd0);
    check("kill_pulses", nm, 32'd1);
    check("kill_trail",  ts, 32'd0);
    check("kill_res",    md_result, 32'hFFFF_FFFF);
    check("kill_exc",    32'(md_exception), 32'd1);
    check("kill_isdiv",  32'(md_is_div), 32'd0);

    // Unit never ready: timeout after 40 BUSY cycles.
    do_op(1'b0, 0, -1, -1, 32'd0, 1'b0, 1'b0, st, nm, nd, nv, vk, ts, tm);
    check("to_stall",  st, 32'd41);
    check("to_validk", vk, 32'd41);
    check("to_res",    md_result, 32'd0);
    check("to_exc",    32'(md_exception), 32'd1);
    check("to_idle",   ts, 32'd0);

    // Ready on the last BUSY cycle wins over timeout.
    do_op(1'b1, 0, 40, -1, 32'h0000_0055, 1'b0, 1'b0, st, nm, nd, nv, vk, ts, tm);
    check("pri_stall",  st, 32'd41);
    check("pri_validk", vk, 32'd41);
    check("pri_res",    md_result, 32'h0000_0055);
    check("pri_exc",    32'(md_exception), 32'd0);
    check("pri_isdiv",  32'(md_is_div), 32'd1);

    // Back-to-back muls: second launch in the cycle after md_valid.
    do_op(1'b0, 0, 3, -1, 32'h0000_1111, 1'b0, 1'b1, st, nm, nd, nv, vk, ts, tm);
    check("b2b1_stall",  st, 32'd4);
    check("b2b1_validk", vk, 32'd4);
    check("b2b1_res",    md_result, 32'h0000_1111);
    check("b2b_pulse2",  tm, 32'd1);
    check("b2b_stall2",  ts, 32'd1);
    do_op(1'b0, 1, 2, -1, 32'h0000_2222, 1'b0, 1'b0, st, nm, nd, nv, vk, ts, tm);
    check("b2b2_stall",  st, 32'd2);
    check("b2b2_validk", vk, 32'd3);
    check("b2b2_pulses", nm, 32'd0);
    check("b2b2_res",    md_result, 32'h0000_2222);

    // Reset mid-BUSY, then a late ready while IDLE.
    drive(RTYPE, DIV, 1'b0, 1'b0, 32'd0, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    drive(NONR, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    next_cycle();
    reset = 1'b0;
    drive(NONR, 5'd0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
    #4;
    check("mrst_stall", 32'(stall_md), 32'd0);
    check("mrst_valid", 32'(md_valid), 32'd0);
    check("mrst_pulse", 32'(ctrl_MULT | ctrl_DIV), 32'd0);
    check("mrst_res",   md_result, 32'd0);
    check("mrst_exc",   32'(md_exception), 32'd0);
    check("mrst_isdiv", 32'(md_is_div), 32'd0);
    next_cycle();
    drive(NONR, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    #4;
    check("mrst_valid2", 32'(md_valid), 32'd0);
    check("mrst_res2",   md_result, 32'd0);
    check("mrst_stall2", 32'(stall_md), 32'd0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
